// File: rtl/seq_add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/seq_add_sub_digit_adder.sv
// DIGIT-bit ripple-carry adder built from full-adder cells; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = cin;
    c_msb_in = 1'b0;
    sum      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_add_sub.sv
// Digit-serial two's-complement adder/subtractor with carry/overflow/zero/negative flags.
// Optional macro SEQ_ADD_SUB_SATURATE_EN clamps overflowing results to the signed range.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output state_t           dbg_state
);

  localparam int NDIG = digit_count(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int LW   = $clog2(WIDTH);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_add_sub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a DONE result stays stable
  // until it is taken.
  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [LW-1:0]    lsb;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             d_cout, d_cmsb, ovf_now;
  logic [WIDTH-1:0] res_next, res_final;

  assign dbg_state = state;
  assign last      = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lsb   = LW'(int'(cnt) * DIGIT);
    a_dig = a_q[lsb +: DIGIT];
    b_dig = b_q[lsb +: DIGIT];
  end

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a        (a_dig),
    .b        (b_dig),
    .cin      (carry_q),
    .sum      (s_dig),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  always_comb begin
    res_next             = result;
    res_next[lsb +: DIGIT] = s_dig;
    ovf_now              = d_cmsb ^ d_cout;
`ifdef SEQ_ADD_SUB_SATURATE_EN
    if (ovf_now)
      res_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_final = res_next;
`else
    res_final = res_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b ^ {WIDTH{add_sub}};
          carry_q <= (add_sub == OP_SUB);
          cnt     <= '0;
        end
        RUN: begin
          carry_q <= d_cout;
          if (last) begin
            // Flags are taken from the final word, after any saturation.
            result    <= res_final;
            carry_out <= d_cout;
            overflow  <= ovf_now;
            zero      <= (res_final == '0);
            negative  <= res_final[WIDTH-1];
          end else begin
            result <= res_next;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub (WIDTH=16, DIGIT=4): directed cases,
// backpressure, mid-run reset and randomized operations against an arithmetic model.
module tb_seq_add_sub;
  import seq_add_sub_pkg::*;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int EW    = WIDTH + 4;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             add_sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out, overflow, zero, negative;
  state_t           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  seq_add_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .add_sub   (add_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry_out, overflow, zero, negative, result} from plain arithmetic.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] op_a,
                                          input logic [WIDTH-1:0] op_b,
                                          input logic op);
    longint sa, sb, s, smax, smin;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             cy, ov;
    sa   = longint'($signed(op_a));
    sb   = longint'($signed(op_b));
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    if (op) begin
      s   = sa - sb;
      res = op_a - op_b;
      cy  = (op_a >= op_b);
    end else begin
      s    = sa + sb;
      wide = {1'b0, op_a} + {1'b0, op_b};
      res  = wide[WIDTH-1:0];
      cy   = wide[WIDTH];
    end
    ov = (s > smax) || (s < smin);
`ifdef SEQ_ADD_SUB_SATURATE_EN
    if (ov) res = op_a[WIDTH-1] ? WIDTH'(smin) : WIDTH'(smax);
`endif
    return {cy, ov, (res == '0), res[WIDTH-1], res};
  endfunction

  task automatic check_outputs(input string tag, input logic [EW-1:0] e);
    check({tag, "_result"},   result,    e[WIDTH-1:0]);
    check({tag, "_negative"}, negative,  e[WIDTH]);
    check({tag, "_zero"},     zero,      e[WIDTH+1]);
    check({tag, "_overflow"}, overflow,  e[WIDTH+2]);
    check({tag, "_carry"},    carry_out, e[WIDTH+3]);
  endtask

  task automatic scramble_inputs();
    in_valid = 1'($urandom_range(0, 1));
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    add_sub  = 1'($urandom_range(0, 1));
  endtask

  // driver: present one operation and return just after its accept edge
  task automatic issue(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                       input logic op);
    int budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("issue_in_ready", in_ready, 1);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    add_sub  = op;
    exp_q.push_back(model(op_a, op_b, op));
    @(posedge clk);
    #1;
    scramble_inputs();
  endtask

  // wait for the result, check latency/values, hold it for bp cycles, then take it
  task automatic collect(input string tag, input int bp);
    int lat = 0;
    logic [EW-1:0] e;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      check({tag, "_in_ready_run"}, in_ready, 0);
      scramble_inputs();
    end
    check({tag, "_latency"}, lat, NDIG);
    check({tag, "_qsize"}, exp_q.size(), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_outputs(tag, e);
    for (int i = 0; i < bp; i++) begin
      scramble_inputs();
      @(posedge clk);
      #1;
      check({tag, "_bp_valid"},    out_valid, 1);
      check({tag, "_bp_in_ready"}, in_ready, 0);
      check_outputs({tag, "_bp"}, e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"},    out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
    check_outputs({tag, "_held"}, e);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    add_sub   = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",    dbg_state, IDLE);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check_outputs("rst", '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    issue(16'h7FFF, 16'h0001, OP_ADD); collect("add_ovf", 0);
    issue(16'h0005, 16'h0005, OP_SUB); collect("sub_zero", 0);
    issue(16'h8000, 16'h0001, OP_SUB); collect("sub_ovf", 1);
    issue(16'h0003, 16'h0005, OP_SUB); collect("sub_borrow", 10);
    issue(16'hFFFF, 16'h0001, OP_ADD); collect("add_carry", 2);

    // reset during the second RUN cycle
    issue(16'h4321, 16'h1111, OP_ADD);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    check("midrst_state",     dbg_state, IDLE);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready, 1);
    check_outputs("midrst", '0);
    issue(16'h1234, 16'h1111, OP_ADD); collect("after_rst", 0);

    for (int i = 0; i < 30; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      collect("rand", int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
